grant_frame_mux4: RTL
=====================

GRANT_FRAME_MUX4 -- requirements
Module: grant_frame_mux4

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, meaning the width of each port data word and of the output data word.
REQ-002 The block SHALL have the following ports:
- clock  in  1  sole clock, all state on rising edge
- nReset  in  1  asynchronous active-low reset
- qvFrameValid  in  4  per-port: a complete frame is pending
- qvPortData  in  4*DATA_W  port p data occupies bits [p*DATA_W +: DATA_W]
- qvPortValid  in  4  per-port: data word available
- qvPortSop  in  4  per-port: start-of-frame marker
- qvPortEop  in  4  per-port: end-of-frame marker
- qvPortRead  out  4  per-port: word consumed this cycle
- qArbitEnable  out  1  enable to the 4-input round-robin arbiter
- qvRequest  out  4  requests to the arbiter
- qvGrant  in  4  grant from the arbiter, one-hot pulse
- qvGrantIndex  in  2  index of the granted port
- qOutValid  out  1  output word valid
- qvOutData  out  DATA_W  output data
- qOutSop  out  1  output start-of-frame
- qOutEop  out  1  output end-of-frame
- qOutReady  in  1  downstream accepts the word
- qvErrCnt  out  8  saturating protocol-error count

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, WAIT, XFER and GAP; every output SHALL be driven from registers except qvPortRead.
REQ-004 In IDLE, when qvFrameValid is not 0, the FSM SHALL register qvRequest <= qvFrameValid and qArbitEnable <= 1 and move to REQ.
- In REQ, qvRequest and qArbitEnable SHALL be held for exactly that one cycle.
- qvRequest and qArbitEnable SHALL be 0 in every other state.
REQ-005 In WAIT, a 2-bit wait counter SHALL start at 0; the grant is expected 2 cycles after the REQ cycle.
- A nonzero qvGrant SHALL store qvGrantIndex into the selected-port register and move to XFER.
- If qvGrant stays 0 for 3 WAIT cycles, the FSM SHALL move to IDLE and increment qvErrCnt.
REQ-006 A grant SHALL be treated as invalid when qvGrant is not one-hot, when qvGrant[qvGrantIndex]=0, or when the granted port had no request in REQ.
- An invalid grant SHALL send the FSM to IDLE and increment qvErrCnt.
REQ-007 In XFER, with sel the selected port, qvPortRead[sel] SHALL equal qvPortValid[sel] && (~qOutValid || qOutReady); all other qvPortRead bits SHALL be 0.
REQ-008 On a read, the block SHALL load qvOutData, qOutSop and qOutEop from port sel and set qOutValid=1.
- qOutValid SHALL clear when qOutReady=1 and no new word is loaded.
- Throughput SHALL be one word per cycle.
REQ-009 The first word read in XFER SHALL carry Sop=1.
- If it does not, the word SHALL still be forwarded and qvErrCnt SHALL be incremented once per frame.
REQ-010 Reading a word with Eop=1 SHALL move the FSM to GAP; GAP SHALL last 1 cycle and then go to IDLE.
- This gives the arbiter its required one idle cycle between arbitration rounds.
REQ-011 The block SHALL NOT lose or duplicate a word while qOutReady=0, and the output registers SHALL be held.
REQ-012 qvErrCnt SHALL saturate at 255; simultaneous error events in one cycle SHALL count as 1.
REQ-013 A grant arriving outside WAIT SHALL be ignored and counted in qvErrCnt.
REQ-014 Changes to qvFrameValid outside IDLE SHALL have no effect until the next IDLE.

Reset
REQ-015 While nReset=0, asynchronously:
- FSM=IDLE, wait counter=0, selected-port register=0
- qvRequest=0, qArbitEnable=0, qvPortRead=0
- qOutValid=0, qvOutData=0, qOutSop=0, qOutEop=0, qvErrCnt=0
REQ-016 A reset asserted mid-frame SHALL abandon the frame without completing it; after release, the block SHALL start in IDLE and SHALL issue no read until a new grant is received.

Verification
REQ-017 Single frame: qvFrameValid=4'b0100 with a 3-word frame on port 2, grant 4'b0100 with index 2 two cycles after REQ, qOutReady=1 -> the expected response is:
- qvRequest=4'b0100 for 1 cycle;
- qvPortRead[2] high for 3 consecutive cycles;
- output words carry Sop on word 1 and Eop on word 3;
- GAP for 1 cycle, then IDLE.
REQ-018 Backpressure: the same frame with qOutReady toggling 1,0,1,0 -> all 3 words are delivered in order, with no read while qOutValid=1 and qOutReady=0.
REQ-019 Timeout: qvFrameValid=4'b0001 and no grant -> the FSM returns to IDLE after 3 WAIT cycles, qvErrCnt=1, and a new REQ is issued the next cycle.
REQ-020 Bad grant: qvGrant=4'b0011 -> no qvPortRead, the FSM goes to IDLE, and qvErrCnt increments by 1.
REQ-021 Round robin with all 4 ports requesting and the arbiter granting 0,1,2,3 in turn -> 4 frames are output in port order, each separated by at least 1 GAP cycle.
REQ-022 Reset during XFER word 2 -> all outputs are 0 immediately; after release, the next transfer begins only after a new REQ/grant.

Source files
------------

// File: rtl/grant_frame_mux4.sv
// grant_frame_mux4: 4:1 frame mux driven by an external round-robin arbiter.
// One request/grant round per frame, then one gap cycle before re-arbitration.

module grant_frame_mux4 #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic [3:0]        qvFrameValid,
  input  logic [4*DATA_W-1:0] qvPortData,
  input  logic [3:0]        qvPortValid,
  input  logic [3:0]        qvPortSop,
  input  logic [3:0]        qvPortEop,
  output logic [3:0]        qvPortRead,
  output logic              qArbitEnable,
  output logic [3:0]        qvRequest,
  input  logic [3:0]        qvGrant,
  input  logic [1:0]        qvGrantIndex,
  output logic              qOutValid,
  output logic [DATA_W-1:0] qvOutData,
  output logic              qOutSop,
  output logic              qOutEop,
  input  logic              qOutReady,
  output logic [7:0]        qvErrCnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_XFER,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  logic [1:0]        wcnt_q, wcnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        mask_q, mask_d;
  logic [3:0]        req_q, req_d;
  logic              arb_q, arb_d;
  logic              first_q, first_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic              osop_q, osop_d;
  logic              oeop_q, oeop_d;
  logic [7:0]        err_q, err_d;

  logic [DATA_W-1:0] p_data;
  logic              p_valid;
  logic              p_sop;
  logic              p_eop;
  logic              rd;
  logic [3:0]        gnt_m1;
  logic              gnt_any;
  logic              gnt_onehot;
  logic              gnt_ok;
  logic              ev_to;
  logic              ev_bad;
  logic              ev_sop;
  logic              ev_late;
  logic              ev_any;

  always_comb begin
    p_data  = '0;
    p_valid = 1'b0;
    p_sop   = 1'b0;
    p_eop   = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (sel_q == 2'(p)) begin
        p_data  = qvPortData[p*DATA_W +: DATA_W];
        p_valid = qvPortValid[p];
        p_sop   = qvPortSop[p];
        p_eop   = qvPortEop[p];
      end
    end
  end

  assign rd = (state_q == S_XFER) && p_valid &&
              (!ov_q || qOutReady);

  assign qvPortRead = rd ? (4'b0001 << sel_q) : 4'b0000;

  // A grant is only trusted if one-hot, self-consistent and requested
  assign gnt_m1     = qvGrant - 4'd1;
  assign gnt_any    = |qvGrant;
  assign gnt_onehot = gnt_any && ((qvGrant & gnt_m1) == 4'b0000);
  assign gnt_ok     = gnt_onehot &&
                      qvGrant[qvGrantIndex] &&
                      mask_q[qvGrantIndex];

  assign ev_late = gnt_any && (state_q != S_WAIT);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    req_d   = 4'b0000;
    arb_d   = 1'b0;
    first_d = first_q;
    ev_to   = 1'b0;
    ev_bad  = 1'b0;
    ev_sop  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|qvFrameValid) begin
          req_d   = qvFrameValid;
          arb_d   = 1'b1;
          mask_d  = qvFrameValid;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        wcnt_d  = 2'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gnt_any) begin
          if (gnt_ok) begin
            sel_d   = qvGrantIndex;
            first_d = 1'b1;
            state_d = S_XFER;
          end else begin
            ev_bad  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (wcnt_q == 2'd2) begin
          ev_to   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_XFER: begin
        if (rd) begin
          first_d = 1'b0;
          ev_sop  = first_q && !p_sop;
          if (p_eop) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ov_d   = ov_q;
    od_d   = od_q;
    osop_d = osop_q;
    oeop_d = oeop_q;
    if (rd) begin
      ov_d   = 1'b1;
      od_d   = p_data;
      osop_d = p_sop;
      oeop_d = p_eop;
    end else if (qOutReady) begin
      ov_d = 1'b0;
    end
  end

  // Concurrent events in one cycle collapse into a single increment
  assign ev_any = ev_to | ev_bad | ev_sop | ev_late;

  always_comb begin
    err_d = err_q;
    if (ev_any && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 2'd0;
      sel_q   <= 2'd0;
      mask_q  <= 4'b0000;
      req_q   <= 4'b0000;
      arb_q   <= 1'b0;
      first_q <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
      arb_q   <= arb_d;
      first_q <= first_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      err_q   <= err_d;
    end
  end

  assign qvRequest    = req_q;
  assign qArbitEnable = arb_q;
  assign qOutValid    = ov_q;
  assign qvOutData    = od_q;
  assign qOutSop      = osop_q;
  assign qOutEop      = oeop_q;
  assign qvErrCnt     = err_q;

endmodule
